dc_store_port: RTL and testbench



---
 rtl/dc_store_port_pkg.sv | 15 +
 rtl/dc_store_port_byte_lane_merge.sv | 16 +
 rtl/dc_store_port.sv | 143 ++++++++++++++
 tb/tb_dc_store_port.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_store_port_pkg.sv
// rtl/dc_store_port_pkg.sv - shared types and encodings for the store-buffer data-cache port.
// DC_STPORT_BYTE_EN is left undefined by default (byte stores behave as word stores).
package dc_store_port_pkg;

  localparam logic DC_TYPE_WORD = 1'b0;
  localparam logic DC_TYPE_BYTE = 1'b1;

  typedef enum logic [1:0] {
    DC_SP_IDLE = 2'd0,
    DC_SP_RD   = 2'd1,
    DC_SP_WR   = 2'd2,
    DC_SP_DONE = 2'd3
  } dc_sp_state_e;

endpackage

// File: rtl/dc_store_port_byte_lane_merge.sv
// rtl/dc_store_port_byte_lane_merge.sv - replaces one little-endian byte lane of a word.
module byte_lane_merge
  import dc_store_port_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = word_i;
    merged_o[{lane_i, 3'b000} +: 8] = byte_i;
  end

endmodule

// File: rtl/dc_store_port.sv
// rtl/dc_store_port.sv - data-cache responder for store-buffer stores/loads over a req/ack word memory.
// Define DC_STPORT_BYTE_EN to enable read-modify-write byte stores.
module dc_store_port
  import dc_store_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_store,
  input  logic              req_load,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_type,
  output logic              ready,
  output logic              hit_dc,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  dc_sp_state_e      state_q;
  logic              ready_q;
  logic              hit_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

`ifdef DC_STPORT_BYTE_EN
  logic              is_load_q;
  logic [1:0]        lane_q;
  logic [7:0]        byte_q;
  logic [DATA_W-1:0] merged;

  byte_lane_merge u_merge (
    .word_i  (mem_rdata),
    .byte_i  (byte_q),
    .lane_i  (lane_q),
    .merged_o(merged)
  );
`else
  logic unused_in;
  assign unused_in = ^{in_type, in_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DC_SP_IDLE;
      ready_q     <= 1'b1;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef DC_STPORT_BYTE_EN
      is_load_q   <= 1'b0;
      lane_q      <= 2'd0;
      byte_q      <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        DC_SP_IDLE: begin
          hit_q <= 1'b0;
          // A simultaneous load is dropped; the store buffer keeps it asserted.
          if (req_store || req_load) begin
            ready_q    <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {in_addr[ADDR_W-1:2], 2'b00};
`ifdef DC_STPORT_BYTE_EN
            is_load_q  <= !req_store;
            lane_q     <= in_addr[1:0];
            byte_q     <= in_wdata[7:0];
`endif
            if (!req_store) begin
              mem_we_q <= 1'b0;
              state_q  <= DC_SP_RD;
            end
`ifdef DC_STPORT_BYTE_EN
            else if (in_type == DC_TYPE_BYTE) begin
              mem_we_q <= 1'b0;
              state_q  <= DC_SP_RD;
            end
`endif
            else begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= in_wdata;
              state_q     <= DC_SP_WR;
            end
          end
        end
        DC_SP_RD: begin
          if (mem_ack) begin
`ifdef DC_STPORT_BYTE_EN
            // RMW: keep mem_req high so the write follows the read with no bubble.
            if (!is_load_q) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merged;
              state_q     <= DC_SP_WR;
            end else
`endif
            begin
              rdata_q   <= mem_rdata;
              mem_req_q <= 1'b0;
              hit_q     <= 1'b1;
              state_q   <= DC_SP_DONE;
            end
          end
        end
        DC_SP_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            hit_q     <= 1'b1;
            state_q   <= DC_SP_DONE;
          end
        end
        DC_SP_DONE: begin
          hit_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= DC_SP_IDLE;
        end
        default: state_q <= DC_SP_IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign hit_dc    = hit_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dc_store_port.sv
// tb/tb_dc_store_port.sv - self-checking bench for dc_store_port with a req/ack memory responder.
module tb_dc_store_port;

`ifdef DC_STPORT_BYTE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_store, req_load, in_type;
  logic [31:0] in_addr, in_wdata;
  logic        ready, hit_dc, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dc_store_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_store(req_store), .req_load(req_load),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_type(in_type),
    .ready(ready), .hit_dc(hit_dc), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} acc_t;
  typedef struct {
    logic ld; logic [31:0] addr; logic [31:0] wd; logic typ;
    int waits; int lat; int nacc; logic [31:0] exp_addr; logic [31:0] exp_data;
  } vec_t;

  acc_t        acc_log[$];
  logic [31:0] mem   [0:1023];
  logic [31:0] model [0:15];
  int wait_cfg = 0;
  int ack_budget = 1000000;
  int acks_given = 0;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: acks after wait_cfg wait cycles, checks request stability while waiting.
  initial begin : responder
    int cnt;
    logic [31:0] a0, d0;
    logic w0;
    mem_ack = 1'b0; mem_rdata = '0; cnt = 0; a0 = '0; d0 = '0; w0 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0; mem_rdata = '0; cnt = 0;
      end else if (!mem_req) cnt = 0;
      if (mem_req) begin
        if (cnt == 0) begin
          a0 = mem_addr; w0 = mem_we; d0 = mem_wdata;
        end else begin
          check("mem_addr_stable", mem_addr, a0);
          check("mem_we_stable", {31'b0, mem_we}, {31'b0, w0});
          check("mem_wdata_stable", mem_wdata, d0);
        end
        if (cnt >= wait_cfg && acks_given < ack_budget) begin
          mem_ack = 1'b1;
          acks_given++;
          acc_log.push_back('{mem_we, mem_addr, mem_wdata});
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          else mem_rdata = mem[mem_addr[11:2]];
        end
        cnt++;
      end
    end
  end

  // Called #1 after an edge with ready=1; returns #1 after the edge following hit_dc.
  task automatic do_req(input logic ld, input logic [31:0] addr, input logic [31:0] wd,
                        input logic typ, output int lat);
    acc_log.delete();
    req_store = !ld; req_load = ld; in_addr = addr; in_wdata = wd; in_type = typ;
    @(posedge clk); #1;
    req_store = 1'b0; req_load = 1'b0;
    check("busy_ready_low", {31'b0, ready}, 32'd0);
    lat = -1;
    for (int j = 0; j < 60; j++) begin
      if (hit_dc) begin
        lat = j + 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("hit_one_cycle", {31'b0, hit_dc}, 32'd0);
    check("ready_back", {31'b0, ready}, 32'd1);
  endtask

  vec_t vt[7];

  initial begin
    int lat, j, idx, lane, nacc;
    logic ld, typ, byte_op;
    logic [31:0] addr, wd, exp_rd;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1'b1; req_store = 1'b0; req_load = 1'b0;
    in_addr = '0; in_wdata = '0; in_type = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_hit", {31'b0, hit_dc}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Directed vectors.
    mem[32'h104 >> 2] = 32'h11223344;
    mem[32'h200 >> 2] = 32'hCAFEF00D;
    vt[0] = '{1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 0, 2, 1, 32'h100, 32'hDEADBEEF};
    vt[1] = '{1'b0, 32'h106, 32'h000000AA, 1'b1, 0, BE ? 3 : 2, BE ? 2 : 1, 32'h104,
              BE ? 32'h11AA3344 : 32'h000000AA};
    vt[2] = '{1'b1, 32'h200, 32'h0, 1'b0, 3, 5, 1, 32'h200, 32'hCAFEF00D};
    vt[3] = '{1'b1, 32'h105, 32'h0, 1'b1, 1, 3, 1, 32'h104,
              BE ? 32'h11AA3344 : 32'h000000AA};
    vt[4] = '{1'b0, 32'h203, 32'hFFFFFF5A, 1'b1, 2, BE ? 7 : 4, BE ? 2 : 1, 32'h200,
              BE ? 32'h5AFEF00D : 32'hFFFFFF5A};
    vt[5] = '{1'b1, 32'h203, 32'h0, 1'b0, 0, 2, 1, 32'h200,
              BE ? 32'h5AFEF00D : 32'hFFFFFF5A};
    vt[6] = '{1'b0, 32'h100, 32'h00000077, 1'b1, 0, BE ? 3 : 2, BE ? 2 : 1, 32'h100,
              BE ? 32'hDEADBE77 : 32'h00000077};
    for (int i = 0; i < 7; i++) begin
      wait_cfg = vt[i].waits;
      do_req(vt[i].ld, vt[i].addr, vt[i].wd, vt[i].typ, lat);
      check($sformatf("v%0d_latency", i), lat, vt[i].lat);
      check($sformatf("v%0d_nacc", i), acc_log.size(), vt[i].nacc);
      if (acc_log.size() > 0) begin
        check($sformatf("v%0d_first_we", i), {31'b0, acc_log[0].we},
              (vt[i].ld || vt[i].nacc == 2) ? 32'd0 : 32'd1);
        check($sformatf("v%0d_addr", i), acc_log[$].addr, vt[i].exp_addr);
        check($sformatf("v%0d_data", i), vt[i].ld ? rdata : acc_log[$].data, vt[i].exp_data);
      end
    end

    // Store and load together: store first, held load accepted 3 edges later.
    wait_cfg = 0;
    acc_log.delete();
    req_store = 1'b1; req_load = 1'b1; in_addr = 32'h300; in_wdata = 32'h12345678; in_type = 1'b0;
    @(posedge clk); #1;
    req_store = 1'b0;
    j = 0;
    while (!ready && j < 20) begin
      @(posedge clk); #1;
      j++;
    end
    check("b2b_gap", j + 1, 3);
    check("simul_first_is_store", (acc_log.size() == 1) ? {31'b0, acc_log[0].we} : 32'hX, 32'd1);
    @(posedge clk); #1;
    req_load = 1'b0;
    j = 0;
    while (!hit_dc && j < 20) begin
      @(posedge clk); #1;
      j++;
    end
    check("simul_load_rdata", rdata, 32'h12345678);
    check("simul_nacc", acc_log.size(), 2);
    @(posedge clk); #1;

    // Randomized ops against a word-array model.
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      mem[i] = model[i];
    end
    for (int n = 0; n < 40; n++) begin
      ld = 1'($urandom_range(0, 1));
      typ = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 63);
      wd = $urandom;
      wait_cfg = $urandom_range(0, 2);
      idx = int'(addr) / 4;
      lane = int'(addr) % 4;
      byte_op = !ld && typ && BE;
      nacc = byte_op ? 2 : 1;
      exp_rd = model[idx];
      if (byte_op)
        model[idx] = (model[idx] & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
      else if (!ld)
        model[idx] = wd;
      do_req(ld, addr, wd, typ, lat);
      check($sformatf("rnd%0d_latency", n), lat, nacc * (wait_cfg + 1) + 1);
      check($sformatf("rnd%0d_nacc", n), acc_log.size(), nacc);
      check($sformatf("rnd%0d_rdata", n), ld ? rdata : exp_rd, exp_rd);
    end
    for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem[i], model[i]);

    // Reset while the write of a byte store is outstanding.
    wait_cfg = 0;
    mem[32'h108 >> 2] = 32'h55667788;
    ack_budget = acks_given + (BE ? 1 : 0);
    acc_log.delete();
    req_store = 1'b1; in_addr = 32'h108; in_wdata = 32'h000000BB; in_type = 1'b1;
    @(posedge clk); #1;
    req_store = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rstmid_no_hit", {31'b0, hit_dc}, 32'd0);
    end
    check("rstmid_reads", acc_log.size(), BE ? 1 : 0);
    check("rstmid_wr_pending", {30'b0, mem_req, mem_we}, 32'd3);
    check("rstmid_wdata", mem_wdata, BE ? 32'h556677BB : 32'h000000BB);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rstmid_ready", {31'b0, ready}, 32'd1);
    check("rstmid_hit", {31'b0, hit_dc}, 32'd0);
    ack_budget = 1000000;
    repeat (4) begin
      @(posedge clk); #1;
      check("rstmid_idle_hit", {30'b0, hit_dc, mem_req}, 32'd0);
    end
    check("rstmid_mem_kept", mem[32'h108 >> 2], 32'h55667788);
    check("rstmid_no_new_acc", acc_log.size(), BE ? 1 : 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
